// File: rtl/mult_acc_5x8_pkg.sv
// Shared constants and state encoding for the 5x8 multiply-accumulate block.
package mult_acc_5x8_pkg;

  localparam int MAX_TERMS = 16;
  localparam int SUM_W     = 17;
  localparam int A_W       = 5;
  localparam int B_W       = 8;
  localparam int PROD_W    = A_W + B_W;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [SUM_W-1:0] zextProd(input logic [PROD_W-1:0] prod);
    return {{(SUM_W-PROD_W){1'b0}}, prod};
  endfunction

endpackage

// File: rtl/mult_acc_5x8_mult.sv
// Combinational unsigned 5-bit by 8-bit multiplier giving an exact 13-bit product.
module Multiplier_5bits_8bits (
  input  logic [4:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [12:0] o_p
);

  assign o_p = {8'd0, i_a} * {5'd0, i_b};

endmodule

// File: rtl/mult_acc_5x8.sv
// Two-stage multiply-accumulate over frames of up to 16 terms, with a
// valid/ready result handshake.
module mult_acc_5x8
  import mult_acc_5x8_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             IN_LAST,
  input  logic [A_W-1:0]   A_NUM,
  input  logic [B_W-1:0]   B_NUM,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [SUM_W-1:0] OUT_SUM,
  output logic [CNT_W-1:0] OUT_COUNT,
  output logic             OUT_TRUNC
);

  state_t              r_state;
  state_t              w_nextState;
  logic [A_W-1:0]      r_a;
  logic [B_W-1:0]      r_b;
  logic                r_s1Valid;
  logic                r_s1Close;
  logic                r_s1Trunc;
  logic [SUM_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_termCnt;
  logic [CNT_W-1:0]    r_acceptCnt;
  logic                r_trunc;
  logic [PROD_W-1:0]   w_prod;
  logic                w_accept;
  logic                w_sixteenth;
  logic                w_close;
  logic                w_release;

  Multiplier_5bits_8bits u_mult (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_prod)
  );

  // Ready drops once a closing beat is in flight so no beat of the next frame
  // can slip in before the result has been handed off.
  assign IN_READY    = ~RST & (r_state != DONE) & ~(r_s1Valid & r_s1Close);
  assign w_accept    = IN_VALID & IN_READY;
  assign w_sixteenth = (r_acceptCnt == CNT_W'(MAX_TERMS - 1));
  assign w_close     = IN_LAST | w_sixteenth;
  assign w_release   = (r_state == DONE) & OUT_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = ACC;
      ACC:     if (r_s1Valid && r_s1Close) w_nextState = DONE;
      DONE:    if (OUT_READY) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a         <= '0;
      r_b         <= '0;
      r_s1Valid   <= 1'b0;
      r_s1Close   <= 1'b0;
      r_s1Trunc   <= 1'b0;
      r_acceptCnt <= '0;
    end else if (w_release) begin
      r_s1Valid   <= 1'b0;
      r_s1Close   <= 1'b0;
      r_s1Trunc   <= 1'b0;
      r_acceptCnt <= '0;
    end else begin
      r_s1Valid <= w_accept;
      if (w_accept) begin
        r_a         <= A_NUM;
        r_b         <= B_NUM;
        r_s1Close   <= w_close;
        r_s1Trunc   <= w_sixteenth & ~IN_LAST;
        r_acceptCnt <= r_acceptCnt + CNT_W'(1);
      end
    end
  end

  // Stage 2: fold the registered product into the running frame total.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_acc     <= '0;
      r_termCnt <= '0;
      r_trunc   <= 1'b0;
    end else if (w_release) begin
      r_acc     <= '0;
      r_termCnt <= '0;
      r_trunc   <= 1'b0;
    end else if (r_s1Valid) begin
      r_acc     <= r_acc + zextProd(w_prod);
      r_termCnt <= r_termCnt + CNT_W'(1);
      if (r_s1Close) r_trunc <= r_s1Trunc;
    end
  end

  assign OUT_VALID = (r_state == DONE);
  assign OUT_SUM   = OUT_VALID ? r_acc     : '0;
  assign OUT_COUNT = OUT_VALID ? r_termCnt : '0;
  assign OUT_TRUNC = OUT_VALID & r_trunc;

endmodule

// File: tb/tb_mult_acc_5x8.sv
// Scoreboard bench for mult_acc_5x8: a frame-level model pushes expected
// results and a monitor pops them whenever the result handshake fires.
module tb_mult_acc_5x8;

  localparam int TERM_LIMIT = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic        IN_LAST;
  logic [4:0]  A_NUM;
  logic [7:0]  B_NUM;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [16:0] OUT_SUM;
  logic [4:0]  OUT_COUNT;
  logic        OUT_TRUNC;

  typedef struct {
    int sum;
    int count;
    int trunc;
  } result_t;

  result_t expQ[$];
  int      nChecks = 0;
  int      nErrors = 0;
  int      modelSum = 0;
  int      modelCnt = 0;
  bit      randMode = 1'b0;
  int      waitCycles;

  mult_acc_5x8 dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_LAST   (IN_LAST),
    .A_NUM     (A_NUM),
    .B_NUM     (B_NUM),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_SUM   (OUT_SUM),
    .OUT_COUNT (OUT_COUNT),
    .OUT_TRUNC (OUT_TRUNC)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Present one beat and hold it until the DUT takes it; returns just after the accepting edge.
  task automatic applyStimulus(input int a, input int b, input bit last, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    A_NUM    = 5'(a);
    B_NUM    = 8'(b);
    IN_LAST  = last;
    IN_VALID = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      if (IN_READY) got = 1'b1;
      else waited++;
    end
    checkOutput("accept_timeout", 32'(got), 32'd1);
    if (got) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic idleCycles(input int n);
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Raise OUT_READY until one result handshake completes.
  task automatic drainResult();
    bit got;
    got = 1'b0;
    OUT_READY = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      if (OUT_VALID) got = 1'b1;
    end
    checkOutput("drain_timeout", 32'(got), 32'd1);
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
  endtask

  // Frame model: every accepted beat adds a*b; a frame closes on LAST or its 16th term.
  always @(negedge CLK) begin
    if (RST) begin
      modelSum = 0;
      modelCnt = 0;
      expQ.delete();
    end else if (IN_VALID && IN_READY) begin
      modelSum += int'(A_NUM) * int'(B_NUM);
      modelCnt++;
      if (IN_LAST || modelCnt == TERM_LIMIT) begin
        expQ.push_back('{modelSum, modelCnt, IN_LAST ? 0 : 1});
        modelSum = 0;
        modelCnt = 0;
      end
    end
  end

  // Monitor: compare each handed-off result against the oldest expected frame.
  always @(negedge CLK) begin
    result_t exp;
    if (!RST) begin
      if (OUT_VALID && OUT_READY) begin
        checkOutput("result_pending", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          exp = expQ.pop_front();
          checkOutput("sb_sum", 32'(OUT_SUM), exp.sum);
          checkOutput("sb_count", 32'(OUT_COUNT), exp.count);
          checkOutput("sb_trunc", 32'(OUT_TRUNC), exp.trunc);
        end
      end else if (!OUT_VALID) begin
        checkOutput("idle_sum", 32'(OUT_SUM), 32'd0);
        checkOutput("idle_count", 32'(OUT_COUNT), 32'd0);
        checkOutput("idle_trunc", 32'(OUT_TRUNC), 32'd0);
      end
    end
  end

  // Random consumer back-pressure while the random phase runs.
  always @(posedge CLK) begin
    #2;
    if (randMode) OUT_READY = 1'($urandom_range(0, 1));
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST       = 1'b1;
    IN_VALID  = 1'b0;
    IN_LAST   = 1'b0;
    A_NUM     = '0;
    B_NUM     = '0;
    OUT_READY = 1'b0;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_in_ready", 32'(IN_READY), 32'd0);
    checkOutput("rst_out_valid", 32'(OUT_VALID), 32'd0);
    checkOutput("rst_sum", 32'(OUT_SUM), 32'd0);
    checkOutput("rst_count", 32'(OUT_COUNT), 32'd0);
    checkOutput("rst_trunc", 32'(OUT_TRUNC), 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    #1 checkOutput("ready_after_rst", 32'(IN_READY), 32'd1);

    // Single beat: result appears on the edge after the accepting edge.
    applyStimulus(31, 255, 1'b1, waitCycles);
    idleCycles(0);
    checkOutput("s1_valid_early", 32'(OUT_VALID), 32'd0);
    checkOutput("s1_ready_closing", 32'(IN_READY), 32'd0);
    @(posedge CLK);
    #1;
    checkOutput("s1_valid", 32'(OUT_VALID), 32'd1);
    checkOutput("s1_sum", 32'(OUT_SUM), 32'd7905);
    checkOutput("s1_count", 32'(OUT_COUNT), 32'd1);
    checkOutput("s1_trunc", 32'(OUT_TRUNC), 32'd0);
    drainResult();
    checkOutput("s1_valid_after", 32'(OUT_VALID), 32'd0);
    checkOutput("s1_ready_after", 32'(IN_READY), 32'd1);

    // Three back-to-back beats.
    applyStimulus(3, 4, 1'b0, waitCycles);
    applyStimulus(5, 6, 1'b0, waitCycles);
    checkOutput("s2_b2b_2", 32'(waitCycles), 32'd0);
    applyStimulus(7, 8, 1'b1, waitCycles);
    checkOutput("s2_b2b_3", 32'(waitCycles), 32'd0);
    idleCycles(0);
    checkOutput("s2_ready_low", 32'(IN_READY), 32'd0);
    idleCycles(3);
    checkOutput("s2_ready_held", 32'(IN_READY), 32'd0);
    checkOutput("s2_sum", 32'(OUT_SUM), 32'd98);
    checkOutput("s2_count", 32'(OUT_COUNT), 32'd3);
    drainResult();

    // Sixteen terms without LAST, then a stalled consumer with a 17th beat waiting.
    for (int i = 0; i < TERM_LIMIT; i++) applyStimulus(31, 255, 1'b0, waitCycles);
    A_NUM = 5'd1;
    B_NUM = 8'd1;
    IN_LAST = 1'b1;
    IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("s3_valid", 32'(OUT_VALID), 32'd1);
      checkOutput("s3_ready_stall", 32'(IN_READY), 32'd0);
      checkOutput("s3_sum", 32'(OUT_SUM), 32'd126480);
      checkOutput("s3_count", 32'(OUT_COUNT), 32'd16);
      checkOutput("s3_trunc", 32'(OUT_TRUNC), 32'd1);
      @(posedge CLK);
      #1;
    end
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
    checkOutput("s3_released", 32'(OUT_VALID), 32'd0);
    applyStimulus(1, 1, 1'b1, waitCycles);
    checkOutput("s3_17th_wait", 32'(waitCycles), 32'd0);
    idleCycles(1);
    checkOutput("s3_next_sum", 32'(OUT_SUM), 32'd1);
    checkOutput("s3_next_count", 32'(OUT_COUNT), 32'd1);
    drainResult();

    // A 16th term that carries LAST is a normal close.
    for (int i = 0; i < TERM_LIMIT - 1; i++) applyStimulus(1, 2, 1'b0, waitCycles);
    applyStimulus(1, 2, 1'b1, waitCycles);
    idleCycles(1);
    checkOutput("s16l_sum", 32'(OUT_SUM), 32'd32);
    checkOutput("s16l_count", 32'(OUT_COUNT), 32'd16);
    checkOutput("s16l_trunc", 32'(OUT_TRUNC), 32'd0);
    drainResult();

    // Gap of idle cycles inside a frame.
    applyStimulus(2, 10, 1'b0, waitCycles);
    idleCycles(3);
    applyStimulus(1, 1, 1'b1, waitCycles);
    idleCycles(1);
    checkOutput("s5_sum", 32'(OUT_SUM), 32'd21);
    checkOutput("s5_count", 32'(OUT_COUNT), 32'd2);
    drainResult();

    // Reset mid-frame discards the partial sum.
    applyStimulus(10, 10, 1'b0, waitCycles);
    applyStimulus(10, 10, 1'b0, waitCycles);
    idleCycles(0);
    RST = 1'b1;
    #1 checkOutput("s6_ready_in_rst", 32'(IN_READY), 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    #1 checkOutput("s6_ready_after", 32'(IN_READY), 32'd1);
    idleCycles(3);
    checkOutput("s6_no_valid", 32'(OUT_VALID), 32'd0);
    applyStimulus(1, 1, 1'b1, waitCycles);
    idleCycles(1);
    checkOutput("s6_sum", 32'(OUT_SUM), 32'd1);
    checkOutput("s6_count", 32'(OUT_COUNT), 32'd1);
    drainResult();

    // Reset while a result is pending drops it.
    applyStimulus(4, 4, 1'b1, waitCycles);
    idleCycles(1);
    checkOutput("s7_valid", 32'(OUT_VALID), 32'd1);
    RST = 1'b1;
    #1;
    checkOutput("s7_valid_rst", 32'(OUT_VALID), 32'd0);
    checkOutput("s7_sum_rst", 32'(OUT_SUM), 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    idleCycles(2);
    checkOutput("s7_no_valid", 32'(OUT_VALID), 32'd0);

    // Random frames with random gaps and random consumer back-pressure.
    randMode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
      applyStimulus($urandom_range(0, 31), $urandom_range(0, 255), ($urandom_range(0, 5) == 0), waitCycles);
    end
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    randMode = 1'b0;
    @(posedge CLK);
    #3 OUT_READY = 1'b1;
    for (int i = 0; i < 100 && (expQ.size() > 0 || OUT_VALID); i++) @(posedge CLK);
    #1;
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    // A frame left open by the random phase is closed here so it is checked too.
    if (modelCnt > 0) begin
      applyStimulus(1, 1, 1'b1, waitCycles);
      IN_VALID = 1'b0;
      for (int i = 0; i < 20 && (expQ.size() > 0 || OUT_VALID); i++) @(posedge CLK);
      #1;
      checkOutput("tail_drained", 32'(expQ.size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
